llc_cmd_issuer: RTL and testbench

Command issue stage directly upstream of the last-level cache model. Accepts decoded trace entries (command, address) over a valid/ready handshake and buffers them in an in-order FIFO. Presents each entry to the LLC's `command`/`address` inputs with a one-cycle `eof` strobe, followed by a programmable idle gap, so the cache task completes before the next entry arrives. Counts issued and filtered entries for the end-of-run statistics report.

---
 rtl/llc_cmd_issuer.sv | 135 +++++++++++++
 tb/tb_llc_cmd_issuer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/llc_cmd_issuer.sv
// llc_cmd_issuer: in-order command FIFO that feeds the LLC model with a one-cycle eof strobe
// followed by a programmable idle gap. Define LLC_CMD_FILTER_EN to drop unsupported commands at enqueue.
module llc_cmd_issuer #(
    parameter int ADDR_BITS = 32,
    parameter int CMDSIZE   = 4,
    parameter int DEPTH     = 8,
    parameter int GAP       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMDSIZE-1:0]   in_cmd,
    input  logic [ADDR_BITS-1:0] in_addr,
    output logic [CMDSIZE-1:0]   llc_cmd,
    output logic [ADDR_BITS-1:0] llc_addr,
    output logic                 llc_eof,
    output logic                 busy,
    output logic [31:0]          issued_count,
    output logic [31:0]          filtered_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CMDSIZE-1:0]   cmd_mem  [DEPTH];
    logic [ADDR_BITS-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 accept;
    logic                 wr_en;
    logic                 pop;
    logic                 fifo_empty;

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a full FIFO.
    assign in_ready   = (occ != OCC_W'(DEPTH));
    assign fifo_empty = (occ == '0);
    assign accept     = in_valid && in_ready;
    assign busy       = !fifo_empty || (state != S_IDLE);

`ifdef LLC_CMD_FILTER_EN
    function automatic logic cmd_supported(input logic [CMDSIZE-1:0] c);
        return (c <= CMDSIZE'(6)) || (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
    endfunction

    logic drop;

    // Dropped entries still complete the handshake; they just never reach the FIFO.
    assign drop  = accept && !cmd_supported(in_cmd);
    assign wr_en = accept && !drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            filtered_count <= '0;
        end else if (drop) begin
            filtered_count <= filtered_count + 32'd1;
        end
    end
`else
    assign wr_en          = accept;
    assign filtered_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cmd_mem[wr_ptr]  <= in_cmd;
            addr_mem[wr_ptr] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop     = (state == S_IDLE) && !fifo_empty;
        llc_eof = (state == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == S_ISSUE) begin
            gap_cnt <= GAP_W'(GAP - 1);
        end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // The LLC-facing command/address load only on a pop and hold through strobe and gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            llc_cmd      <= '0;
            llc_addr     <= '0;
            issued_count <= '0;
        end else if (pop) begin
            llc_cmd      <= cmd_mem[rd_ptr];
            llc_addr     <= addr_mem[rd_ptr];
            issued_count <= issued_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Self-checking bench for llc_cmd_issuer: directed vector table, corner sequences and
// randomized traffic against a queue-based timing model of the issue stage.
module tb_llc_cmd_issuer;
    localparam int ADDR_BITS = 32;
    localparam int CMDSIZE   = 4;
    localparam int DEPTH     = 8;
    localparam int GAP       = 2;
    localparam int NV        = 8;
`ifdef LLC_CMD_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_addr = '0;
    logic        in_ready;
    logic [3:0]  llc_cmd;
    logic [31:0] llc_addr;
    logic        llc_eof;
    logic        busy;
    logic [31:0] issued_count;
    logic [31:0] filtered_count;

    int n_chk  = 0;
    int n_pass = 0;

    llc_cmd_issuer #(
        .ADDR_BITS(ADDR_BITS), .CMDSIZE(CMDSIZE), .DEPTH(DEPTH), .GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .llc_cmd(llc_cmd), .llc_addr(llc_addr),
        .llc_eof(llc_eof), .busy(busy), .issued_count(issued_count),
        .filtered_count(filtered_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic bit enqueued(input logic [3:0] c);
        return !FILT || (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

    // Reference model: accepted entries wait in a queue; an entry strobes two cycles after
    // acceptance, but never sooner than GAP+2 cycles after the previous strobe.
    typedef struct { logic [3:0] cmd; logic [31:0] addr; int acc; } ent_t;
    ent_t q[$];
    int cyc = 0, last_s = -1000, exp_c = 0, exp_pushed = 0, exp_filt = 0, n_strobes = 0;
    bit eof_prev = 1'b0, rst_prev = 1'b1, saw_full = 1'b0;
    logic [3:0]  cmd_prev = '0;
    logic [31:0] addr_prev = '0;

    always @(negedge clk) begin
        ent_t e;
        cyc++;
        if (rst) begin
            q.delete();
            last_s = -1000; exp_pushed = 0; exp_filt = 0; n_strobes = 0;
            eof_prev = 1'b0; rst_prev = 1'b1;
        end else begin
            exp_c = 0;
            if (q.size() != 0)
                exp_c = (last_s + GAP + 2 > q[0].acc + 2) ? last_s + GAP + 2 : q[0].acc + 2;
            if (llc_eof) begin
                chk("eof_not_consecutive", eof_prev, 0);
                chk("strobe_has_entry", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    n_strobes++;
                    chk("strobe_cycle", cyc, exp_c);
                    chk("strobe_cmd", llc_cmd, e.cmd);
                    chk("strobe_addr", llc_addr, e.addr);
                    chk("issued_count", issued_count, n_strobes);
                    last_s = cyc;
                end
            end else begin
                if (q.size() != 0 && cyc == exp_c) chk("missing_strobe", llc_eof, 1);
                if (!rst_prev) begin
                    chk("hold_cmd", llc_cmd, cmd_prev);
                    chk("hold_addr", llc_addr, addr_prev);
                end
            end
            chk("in_ready", in_ready, q.size() != DEPTH);
            chk("busy", busy, (q.size() != 0) || (cyc - last_s <= GAP));
            chk("filtered_count", filtered_count, exp_filt);
            if (!in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) begin
                if (enqueued(in_cmd)) begin
                    q.push_back('{in_cmd, in_addr, cyc});
                    exp_pushed++;
                end else begin
                    exp_filt++;
                end
            end
            eof_prev = llc_eof; cmd_prev = llc_cmd; addr_prev = llc_addr; rst_prev = 1'b0;
        end
    end

    typedef struct { logic [3:0] cmd; logic [31:0] addr; bit exp_strobe; } vec_t;
    vec_t vt[NV];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int n = 0;
        in_valid = 1'b1; in_cmd = c; in_addr = a;
        while (!in_ready && n < 100) begin step(); n++; end
        if (n >= 100) chk("push_ready_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin step(); n++; end
        chk("drain_within_budget", n < 400, 1);
    endtask

    // Single entry from idle: eof exactly one cycle after the accept edge+1, busy until gap ends.
    task automatic run_vec(input vec_t v);
        in_valid = 1'b1; in_cmd = v.cmd; in_addr = v.addr;
        step();
        in_valid = 1'b0;
        chk("vec_k0_eof", llc_eof, 0);
        chk("vec_k0_busy", busy, v.exp_strobe);
        for (int k = 1; k <= GAP + 2; k++) begin
            step();
            chk("vec_eof", llc_eof, v.exp_strobe && (k == 1));
            chk("vec_busy", busy, v.exp_strobe && (k <= GAP + 1));
            if (v.exp_strobe) begin
                chk("vec_cmd", llc_cmd, v.cmd);
                chk("vec_addr", llc_addr, v.addr);
            end
        end
        chk("vec_issued", issued_count, exp_pushed);
        chk("vec_filtered", filtered_count, exp_filt);
    endtask

    initial begin
        int n;
        bit saw;
        vt[0] = '{4'd0,  32'h0000_1000, 1'b1};
        vt[1] = '{4'd7,  32'h0000_2000, !FILT};
        vt[2] = '{4'd15, 32'h0000_3000, !FILT};
        vt[3] = '{4'd9,  32'h0000_4000, 1'b1};
        vt[4] = '{4'd8,  32'hFFFF_FFFF, 1'b1};
        vt[5] = '{4'd3,  32'hA5A5_5A5A, 1'b1};
        vt[6] = '{4'd6,  32'h8000_0001, 1'b1};
        vt[7] = '{4'd1,  32'h0000_0000, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_llc_cmd", llc_cmd, 0);
        chk("rst_llc_addr", llc_addr, 0);
        chk("rst_llc_eof", llc_eof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_filtered", filtered_count, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vt[i]);

        // Max-rate burst long enough to fill the FIFO despite the ongoing pops.
        saw_full = 1'b0;
        for (int i = 0; i < 12; i++) push(4'(i % 7), 32'h0001_0000 + 32'(i) * 32'h10);
        wait_idle();
        chk("burst_full_seen", saw_full, 1);
        chk("burst_issued", issued_count, exp_pushed);

        push(4'd7, 32'h0000_0700);
        push(4'd15, 32'h0000_0F00);
        push(4'd9, 32'h0000_0900);
        wait_idle();
        chk("filter_seq_issued", issued_count, exp_pushed);
        chk("filter_seq_filtered", filtered_count, exp_filt);

        // Reset while entries are queued and the FSM sits in its gap.
        for (int i = 0; i < 8; i++) push(4'(i % 7), 32'h0002_0000 + 32'(i) * 32'h4);
        n = 0;
        while (!llc_eof && n < 20) begin step(); n++; end
        chk("mid_wait_strobe", n < 20, 1);
        step();
        chk("mid_in_gap_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_llc_cmd", llc_cmd, 0);
        chk("mid_rst_llc_addr", llc_addr, 0);
        chk("mid_rst_llc_eof", llc_eof, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_issued", issued_count, 0);
        chk("mid_rst_filtered", filtered_count, 0);
        saw = 1'b0;
        repeat (12) begin step(); saw = saw | llc_eof; end
        chk("mid_rst_no_strobe", saw, 0);

        // Twenty entries with idle gaps so both pointers wrap twice.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push(4'($urandom_range(0, 15)), $urandom);
        end
        wait_idle();
        chk("wrap_issued", issued_count, exp_pushed);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) push(4'($urandom_range(0, 15)), $urandom);
            else step();
        end
        wait_idle();
        chk("final_queue_empty", q.size(), 0);
        chk("final_issued", issued_count, exp_pushed);
        chk("final_filtered", filtered_count, exp_filt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
